// File: rtl/sound_request_arbiter.sv
// Round-robin arbiter sharing the song player between sound requesters.
// Enforces a silent gap between songs and aborts songs that never end.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   req          per-requester level request, held until granted
//   req_song     song id per requester, slice i = [i*SONG_W +: SONG_W]
//   mute         suppress playback (granted requests are dropped)
//   player_done  one-cycle pulse from the player at end of song
//   grant        one-hot, one-cycle pulse: request accepted
//   play_en      player enable, high for the whole playback
//   song_sel     song id to the player, stable while play_en is high
//   busy         high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when a playback is aborted by timeout
module sound_request_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int SONG_W   = 2,
   parameter int MIN_GAP  = 1000,
   parameter int MAX_PLAY = 50000000,
   parameter int PTR_W    = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SONG_W-1:0]  req_song,
   input  logic                       mute,
   input  logic                       player_done,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       play_en,
   output logic [SONG_W-1:0]          song_sel,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int PLAY_W = $clog2(MAX_PLAY);
   localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   localparam logic [PLAY_W-1:0] PLAY_LAST = PLAY_W'(MAX_PLAY - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            state;
   logic [PTR_W-1:0]  last;
   logic [PLAY_W-1:0] play_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic              win_found;
   logic [PTR_W-1:0]  win_idx;

   // Scan from the farthest candidate down to last+1 so that the
   // nearest requester after the pointer overwrites the others.
   function automatic logic [PTR_W:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [PTR_W-1:0]   l
   );
      logic [PTR_W:0]   res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = PTR_W'((int'(l) + k) % NUM_REQ);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      {win_found, win_idx} = rr_pick(req, last);
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         grant       <= '0;
         play_en     <= 1'b0;
         song_sel    <= '0;
         timeout_err <= 1'b0;
         play_cnt    <= '0;
         gap_cnt     <= '0;
         last        <= PTR_W'(NUM_REQ - 1);
      end else begin
         grant       <= '0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  grant <= NUM_REQ'(1) << win_idx;
                  last  <= win_idx;
                  // Under mute the request is consumed without playing.
                  if (!mute) begin
                     play_en  <= 1'b1;
                     song_sel <= req_song[int'(win_idx)*SONG_W +: SONG_W];
                     play_cnt <= '0;
                     state    <= S_PLAY;
                  end
               end
            end
            S_PLAY: begin
               if (player_done || mute || play_cnt == PLAY_LAST) begin
                  play_en     <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
                  // Only a genuine expiry is an error; done wins a tie.
                  timeout_err <= !(player_done || mute);
               end else begin
                  play_cnt <= play_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               play_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Self-checking bench for sound_request_arbiter: directed scenarios
// plus random traffic, checked every cycle against a behavioural model.
module tb_sound_request_arbiter;

   localparam int N        = 3;
   localparam int SW       = 2;
   localparam int MIN_GAP  = 4;
   localparam int MAX_PLAY = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*SW-1:0] req_song;
   logic          mute;
   logic          player_done;
   logic [N-1:0]  grant;
   logic          play_en;
   logic [SW-1:0] song_sel;
   logic          busy;
   logic          timeout_err;

   sound_request_arbiter #(
      .NUM_REQ (N),
      .SONG_W  (SW),
      .MIN_GAP (MIN_GAP),
      .MAX_PLAY(MAX_PLAY),
      .PTR_W   (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_song   (req_song),
      .mute       (mute),
      .player_done(player_done),
      .grant      (grant),
      .play_en    (play_en),
      .song_sel   (song_sel),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: mode 0 = idle, 1 = playing, 2 = silent gap.
   // m_age counts playing cycles so far (1 on the first),
   // m_left counts gap cycles still to run.
   int           m_mode, m_age, m_left, m_last;
   logic [N-1:0] m_grant;
   logic         m_play, m_to;
   logic [SW-1:0] m_song;

   task automatic model_step();
      int w;
      bit found;
      if (reset) begin
         m_mode = 0; m_age = 0; m_left = 0; m_last = N - 1;
         m_grant = '0; m_play = 0; m_to = 0; m_song = '0;
         return;
      end
      m_grant = '0;
      m_to = 0;
      if (m_mode == 0) begin
         found = 0;
         w = 0;
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (!found && req[i]) begin
               found = 1;
               w = i;
            end
         end
         if (found) begin
            m_grant = N'(1 << w);
            m_last = w;
            if (!mute) begin
               m_play = 1;
               m_song = req_song[w*SW +: SW];
               m_mode = 1;
               m_age = 1;
            end
         end
      end else if (m_mode == 1) begin
         if (player_done || mute || m_age == MAX_PLAY) begin
            m_to = !player_done && !mute;
            m_play = 0;
            m_mode = 2;
            m_left = MIN_GAP;
         end else begin
            m_age++;
         end
      end else begin
         if (m_left == 1) m_mode = 0;
         else m_left--;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("grant", grant, m_grant);
      check("play_en", play_en, m_play);
      check("song_sel", song_sel, m_song);
      check("busy", busy, m_mode != 0);
      check("timeout_err", timeout_err, m_to);
      // Requesters drop their line as soon as they see their grant.
      req = req & ~grant;
   endtask

   task automatic wait_grant(output logic [N-1:0] g);
      int n = 0;
      while (grant == '0 && n < 64) begin
         tick();
         n++;
      end
      if (grant == '0) check("grant_wait", 0, 1);
      g = grant;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 64) begin
         tick();
         n++;
      end
      check("idle_wait", busy, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [N-1:0] g;
   int           cnt;

   initial begin
      reset = 1'b1;
      req = '0;
      req_song = '0;
      mute = 1'b0;
      player_done = 1'b0;
      @(negedge clock);
      do_reset();
      check("rst_grant", grant, 0);
      check("rst_play_en", play_en, 0);
      check("rst_song_sel", song_sel, 0);
      check("rst_busy", busy, 0);

      // Single request
      req_song = 6'b00_11_00;
      req = 3'b010;
      tick();
      check("single_grant", grant, 3'b010);
      check("single_play", play_en, 1);
      check("single_song", song_sel, 3);
      tick();
      check("single_grant_pulse", grant, 0);
      repeat (7) tick();
      player_done = 1'b1;
      tick();
      player_done = 1'b0;
      check("single_done_play", play_en, 0);
      check("single_gap_busy", busy, 1);
      repeat (3) tick();
      check("single_gap_end_busy", busy, 1);
      tick();
      check("single_idle", busy, 0);

      // Round robin, twice, from a fresh pointer
      do_reset();
      req_song = 6'b10_01_00;
      for (int r = 0; r < 2; r++) begin
         req = 3'b111;
         for (int j = 0; j < N; j++) begin
            wait_grant(g);
            check("rr_order", g, 3'b001 << j);
            check("rr_song", song_sel, j);
            repeat (2) tick();
            player_done = 1'b1;
            tick();
            player_done = 1'b0;
         end
         wait_idle();
      end

      // Timeout
      req = 3'b001;
      wait_grant(g);
      cnt = 1;
      while (play_en && cnt < 64) begin
         tick();
         if (play_en) cnt++;
      end
      check("to_play_len", cnt, MAX_PLAY);
      check("to_err", timeout_err, 1);
      tick();
      check("to_err_pulse", timeout_err, 0);
      wait_idle();

      // Done on the last allowed cycle beats the timeout
      req = 3'b001;
      wait_grant(g);
      repeat (MAX_PLAY - 1) tick();
      check("coll_still_play", play_en, 1);
      player_done = 1'b1;
      tick();
      player_done = 1'b0;
      check("coll_play", play_en, 0);
      check("coll_err", timeout_err, 0);
      wait_idle();

      // Muted request is consumed silently
      mute = 1'b1;
      req = 3'b100;
      tick();
      check("mute_grant", grant, 3'b100);
      check("mute_play", play_en, 0);
      check("mute_busy", busy, 0);
      mute = 1'b0;
      tick();
      // Mute during playback aborts without error
      req = 3'b001;
      wait_grant(g);
      repeat (3) tick();
      mute = 1'b1;
      tick();
      mute = 1'b0;
      check("mute_abort_play", play_en, 0);
      check("mute_abort_err", timeout_err, 0);
      check("mute_abort_busy", busy, 1);
      wait_idle();

      // Reset in the middle of a playback
      req = 3'b010;
      wait_grant(g);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_play", play_en, 0);
      check("midrst_grant", grant, 0);
      check("midrst_busy", busy, 0);
      req = 3'b111;
      wait_grant(g);
      check("midrst_first", g, 3'b001);
      req = '0;
      wait_idle();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(5) == 0) begin
               req_song[i*SW +: SW] = SW'($urandom);
               req[i] = 1'b1;
            end
         end
         player_done = ($urandom_range(9) == 0);
         mute = ($urandom_range(39) == 0);
         reset = ($urandom_range(499) == 0);
         tick();
      end
      reset = 1'b0;
      mute = 1'b0;
      player_done = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
